pixel_plot_sink: RTL and testbench



---
 rtl/pixel_plot_sink.sv | 106 ++++++++++
 tb/tb_pixel_plot_sink.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: 160x120 shadow framebuffer with collision reporting, read port and clear sweep.
// Optional: define PIXEL_PLOT_SINK_AUTOCLEAR_EN to launch a clear sweep right after reset.
module pixel_plot_sink #(
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int CBITS = 3,
    parameter logic [CBITS-1:0] BG_COLOUR = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [7:0]       x,
    input  logic [6:0]       y,
    input  logic [CBITS-1:0] colour,
    input  logic             plot,
    input  logic [7:0]       rd_x,
    input  logic [6:0]       rd_y,
    input  logic             rd_en,
    output logic [CBITS-1:0] rd_colour,
    output logic             rd_valid,
    input  logic             clear,
    output logic             busy,
    output logic             hit,
    output logic [CBITS-1:0] hit_colour,
    output logic             oob,
    output logic             drop
);
    localparam int NPIX = XSCREEN * YSCREEN;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t state, state_n;
    logic [CBITS-1:0] mem [0:NPIX-1];
    logic [14:0] clr_addr, plot_addr, rd_addr, wr_addr;
    logic [CBITS-1:0] wr_data;
    logic plot_oob, rd_oob, start, blocked, accept, we, auto_go;

    function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
        return (XSCREEN == 160) ? ({8'd0, py} << 7) + ({8'd0, py} << 5) + {7'd0, px}
                                : 15'(py * XSCREEN) + {7'd0, px};
    endfunction

`ifdef PIXEL_PLOT_SINK_AUTOCLEAR_EN
    logic auto_pend;
    // Remember that reset was just released so the first free cycle starts a sweep
    always_ff @(posedge Clock) begin
        auto_pend <= Reset;
    end
    assign auto_go = auto_pend;
`else
    assign auto_go = 1'b0;
`endif

    // Address decode, range checks and write-port arbitration (sweep owns the port while clearing)
    always_comb begin
        plot_addr = pix_addr(x, y);
        rd_addr   = pix_addr(rd_x, rd_y);
        plot_oob  = (32'(x) >= XSCREEN) || (32'(y) >= YSCREEN);
        rd_oob    = (32'(rd_x) >= XSCREEN) || (32'(rd_y) >= YSCREEN);
        start     = (state == S_IDLE) && (clear || auto_go);
        blocked   = (state == S_CLEAR) || start;
        accept    = plot && !blocked && !plot_oob;
        we        = !Reset && ((state == S_CLEAR) || accept);
        wr_addr   = (state == S_CLEAR) ? clr_addr : plot_addr;
        wr_data   = (state == S_CLEAR) ? BG_COLOUR : colour;
    end

    // Next-state and busy decode for the clear sequencer
    always_comb begin
        busy    = (state == S_CLEAR);
        state_n = (state == S_IDLE)  ? (start ? S_CLEAR : S_IDLE) :
                  (state == S_CLEAR) ? ((clr_addr == 15'(NPIX - 1)) ? S_DONE : S_CLEAR) :
                                       S_IDLE;
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Framebuffer write port; contents survive reset
    always_ff @(posedge Clock) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Read-before-write sampling of old pixel, read port, status pulses and sweep address
    always_ff @(posedge Clock) begin
        if (Reset) begin
            clr_addr   <= '0;
            rd_colour  <= '0;
            rd_valid   <= 1'b0;
            hit        <= 1'b0;
            hit_colour <= '0;
            oob        <= 1'b0;
            drop       <= 1'b0;
        end else begin
            clr_addr <= start ? '0 : (state == S_CLEAR) ? clr_addr + 15'd1 : clr_addr;
            rd_valid <= rd_en;
            if (rd_en) rd_colour <= rd_oob ? BG_COLOUR : mem[rd_addr];
            hit <= accept && (mem[plot_addr] != BG_COLOUR);
            if (accept) hit_colour <= mem[plot_addr];
            oob  <= (plot && !blocked && plot_oob) || (rd_en && rd_oob);
            drop <= plot && blocked;
        end
    end
endmodule

// File: tb/tb_pixel_plot_sink.sv
// tb_pixel_plot_sink: directed self-checking bench for pixel_plot_sink (default build).
module tb_pixel_plot_sink;
    logic       Clock = 1'b0, Reset = 1'b1;
    logic [7:0] x = '0, rd_x = '0;
    logic [6:0] y = '0, rd_y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0, rd_en = 1'b0, clear = 1'b0;
    logic [2:0] rd_colour, hit_colour;
    logic       rd_valid, busy, hit, oob, drop;
    int pass_cnt = 0, total = 0;

    always #5 Clock = ~Clock;

    pixel_plot_sink dut (
        .Clock(Clock), .Reset(Reset), .x(x), .y(y), .colour(colour), .plot(plot),
        .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en), .rd_colour(rd_colour), .rd_valid(rd_valid),
        .clear(clear), .busy(busy), .hit(hit), .hit_colour(hit_colour), .oob(oob), .drop(drop)
    );

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic rd_px(input logic [7:0] px, input logic [6:0] py);
        rd_x = px; rd_y = py; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic set_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] c);
        x = px; y = py; colour = c; plot = 1'b1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        step(); step();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else pass_cnt++;
        total++; if (rd_colour !== 3'b000) $display("FAIL reset_rd_colour got=%b exp=000", rd_colour); else pass_cnt++;
        total++; if (hit !== 1'b0 || oob !== 1'b0 || drop !== 1'b0) $display("FAIL reset_pulses got=%b%b%b exp=000", hit, oob, drop); else pass_cnt++;
        total++; if (hit_colour !== 3'b000) $display("FAIL reset_hit_colour got=%b exp=000", hit_colour); else pass_cnt++;
        Reset = 1'b0;
        step();
        total++; if (busy !== 1'b0) $display("FAIL idle_after_reset_busy got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_clear;
        int n;
        clear = 1'b1;
        step();
        clear = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 30000) begin
            n++;
            step();
        end
        total++; if (n != 19200) $display("FAIL clear_busy_cycles got=%0d exp=19200", n); else pass_cnt++;
        rd_px(0, 0);
        total++; if (rd_valid !== 1'b1 || rd_colour !== 3'b000) $display("FAIL rd_0_0 got=%b/%b exp=1/000", rd_valid, rd_colour); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL idle_after_done got=%b exp=0", busy); else pass_cnt++;
        step();
        total++; if (rd_valid !== 1'b0) $display("FAIL rd_valid_pulse got=%b exp=0", rd_valid); else pass_cnt++;
        rd_px(159, 119);
        total++; if (rd_valid !== 1'b1 || rd_colour !== 3'b000) $display("FAIL rd_159_119 got=%b/%b exp=1/000", rd_valid, rd_colour); else pass_cnt++;
        rd_px(80, 60);
        total++; if (rd_valid !== 1'b1 || rd_colour !== 3'b000) $display("FAIL rd_80_60 got=%b/%b exp=1/000", rd_valid, rd_colour); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        set_plot(10, 20, 3'b010);
        step();
        total++; if (hit !== 1'b0 || hit_colour !== 3'b000) $display("FAIL plot1 hit/colour got=%b/%b exp=0/000", hit, hit_colour); else pass_cnt++;
        colour = 3'b100;
        step();
        plot = 1'b0;
        total++; if (hit !== 1'b1 || hit_colour !== 3'b010) $display("FAIL plot2 hit/colour got=%b/%b exp=1/010", hit, hit_colour); else pass_cnt++;
        step();
        total++; if (hit !== 1'b0 || hit_colour !== 3'b010) $display("FAIL hit_pulse hit/colour got=%b/%b exp=0/010", hit, hit_colour); else pass_cnt++;
        rd_px(10, 20);
        total++; if (rd_colour !== 3'b100) $display("FAIL rd_10_20 got=%b exp=100", rd_colour); else pass_cnt++;
    endtask

    task automatic test_oob;
        set_plot(160, 5, 3'b111);
        step();
        plot = 1'b0;
        total++; if (oob !== 1'b1 || hit !== 1'b0 || drop !== 1'b0) $display("FAIL plot_oob oob/hit/drop got=%b%b%b exp=100", oob, hit, drop); else pass_cnt++;
        total++; if (hit_colour !== 3'b010) $display("FAIL plot_oob_hold got=%b exp=010", hit_colour); else pass_cnt++;
        step();
        total++; if (oob !== 1'b0) $display("FAIL oob_pulse got=%b exp=0", oob); else pass_cnt++;
        rd_px(5, 120);
        total++; if (oob !== 1'b1 || rd_valid !== 1'b1 || rd_colour !== 3'b000) $display("FAIL rd_oob oob/valid/col got=%b/%b/%b exp=1/1/000", oob, rd_valid, rd_colour); else pass_cnt++;
        rd_px(0, 6);
        total++; if (rd_colour !== 3'b000 || oob !== 1'b0) $display("FAIL no_wrap_write col/oob got=%b/%b exp=000/0", rd_colour, oob); else pass_cnt++;
        rd_px(159, 5);
        total++; if (rd_colour !== 3'b000 || oob !== 1'b0) $display("FAIL rd_159_5 col/oob got=%b/%b exp=000/0", rd_colour, oob); else pass_cnt++;
    endtask

    task automatic test_drop;
        int n;
        clear = 1'b1;
        step();
        clear = 1'b0;
        n = 1;
        set_plot(1, 1, 3'b001);
        clear = 1'b1;
        step();
        plot = 1'b0;
        clear = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL drop_busy got=%b exp=1", busy); else pass_cnt++;
        total++; if (drop !== 1'b1 || hit !== 1'b0) $display("FAIL drop drop/hit got=%b/%b exp=1/0", drop, hit); else pass_cnt++;
        n = 2;
        while (n < 30000) begin
            step();
            if (busy !== 1'b1) break;
            n++;
        end
        total++; if (n != 19200) $display("FAIL clear_ignored_mid_sweep got=%0d exp=19200", n); else pass_cnt++;
        rd_px(1, 1);
        total++; if (rd_colour !== 3'b000) $display("FAIL rd_1_1_after_drop got=%b exp=000", rd_colour); else pass_cnt++;
    endtask

    task automatic test_reset_mid_clear;
        set_plot(100, 0, 3'b101);
        step();
        set_plot(80, 62, 3'b110);
        step();
        plot = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (5000) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL reset_mid_busy got=%b exp=0", busy); else pass_cnt++;
        total++; if (hit_colour !== 3'b000) $display("FAIL reset_mid_hit_colour got=%b exp=000", hit_colour); else pass_cnt++;
        step();
        total++; if (busy !== 1'b0) $display("FAIL no_restart_busy got=%b exp=0", busy); else pass_cnt++;
        rd_px(100, 0);
        total++; if (rd_colour !== 3'b000) $display("FAIL rd_addr100 got=%b exp=000", rd_colour); else pass_cnt++;
        rd_px(80, 62);
        total++; if (rd_colour !== 3'b110) $display("FAIL rd_addr10000 got=%b exp=110", rd_colour); else pass_cnt++;
    endtask

    task automatic test_same_cycle;
        set_plot(30, 30, 3'b011);
        rd_x = 30; rd_y = 30; rd_en = 1'b1;
        step();
        plot = 1'b0;
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_colour !== 3'b000) $display("FAIL same_cycle_rd got=%b/%b exp=1/000", rd_valid, rd_colour); else pass_cnt++;
        total++; if (hit !== 1'b0) $display("FAIL same_cycle_hit got=%b exp=0", hit); else pass_cnt++;
        rd_px(30, 30);
        total++; if (rd_colour !== 3'b011) $display("FAIL rd_after_write got=%b exp=011", rd_colour); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_back_to_back();
        test_oob();
        test_drop();
        test_reset_mid_clear();
        test_same_cycle();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
